// File: rtl/mac_arbiter.sv
// rtl/mac_arbiter.sv - round-robin arbiter sharing one coefficient ROM port and MAC between two sequencers
//
// Purpose: grants the shared ROM/MAC datapath to one of two transform
// sequencers at a time, holds it for one coefficient computation, clears the
// MAC on every hand-over and captures each finished accumulation.
// Optional feature: define MAC_ARB_WATCHDOG_EN to force release of a grant
// that issues more than MAX_OPS accumulate strobes (sets sticky wd_err_o).
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   req*_i, addr*_i,        per-requester request, ROM address, ROM read
//   rd_en*_i, acc*_i,       enable, accumulate strobe and coefficient-done
//   done*_i                 pulse
//   mac_result_i            MAC accumulator output
//   gnt*_o                  grant (one-hot or zero)
//   rom_addr_o, rom_rd_en_o muxed ROM port
//   mac_active_o            muxed accumulate enable
//   mac_rst_n_o             MAC clear, active-low
//   res*_o, res_valid*_o    captured result and one-cycle update pulse
//   wd_err_o                sticky watchdog error
module mac_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 6,
  parameter int MAX_OPS = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic              rd_en0_i,
  input  logic              rd_en1_i,
  input  logic              acc0_i,
  input  logic              acc1_i,
  input  logic              done0_i,
  input  logic              done1_i,
  input  logic [DATA_W-1:0] mac_result_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  output logic              rom_rd_en_o,
  output logic              mac_active_o,
  output logic              mac_rst_n_o,
  output logic [DATA_W-1:0] res0_o,
  output logic [DATA_W-1:0] res1_o,
  output logic              res_valid0_o,
  output logic              res_valid1_o,
  output logic              wd_err_o
);

`ifdef MAC_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam int                OPS_W   = ADDR_W + 1;
  localparam logic [OPS_W-1:0]  OPS_MAX = OPS_W'(MAX_OPS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_FLUSH  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [OPS_W-1:0]   ops_q, ops_d;
  logic [DATA_W-1:0]  res0_q, res1_q;
  logic               res_valid0_q, res_valid1_q;
  logic               wd_err_q;
  logic               cap0, cap1, wd_fire;
  state_t             pick_state;

  // Arbitration choice used from both IDLE and FLUSH; ptr breaks ties.
  always_comb begin
    pick_state = ST_IDLE;
    if (req0_i && req1_i) begin
      pick_state = ptr_q ? ST_GRANT1 : ST_GRANT0;
    end else if (req0_i) begin
      pick_state = ST_GRANT0;
    end else if (req1_i) begin
      pick_state = ST_GRANT1;
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Done takes precedence over a request drop and over the
  // watchdog so a finished coefficient is never lost.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ops_d   = '0;
    cap0    = 1'b0;
    cap1    = 1'b0;
    wd_fire = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        ops_d = acc0_i ? ops_q + 1'b1 : ops_q;
        if (done0_i) begin
          cap0    = 1'b1;
          state_d = ST_FLUSH;
          ptr_d   = 1'b1;
        end else if (!req0_i) begin
          state_d = ST_FLUSH;
          ptr_d   = 1'b1;
        end else if (WD_EN && acc0_i && (ops_q == OPS_MAX)) begin
          wd_fire = 1'b1;
          state_d = ST_FLUSH;
          ptr_d   = 1'b1;
        end
      end
      ST_GRANT1: begin
        ops_d = acc1_i ? ops_q + 1'b1 : ops_q;
        if (done1_i) begin
          cap1    = 1'b1;
          state_d = ST_FLUSH;
          ptr_d   = 1'b0;
        end else if (!req1_i) begin
          state_d = ST_FLUSH;
          ptr_d   = 1'b0;
        end else if (WD_EN && acc1_i && (ops_q == OPS_MAX)) begin
          wd_fire = 1'b1;
          state_d = ST_FLUSH;
          ptr_d   = 1'b0;
        end
      end
      default: begin
        state_d = pick_state;
      end
    endcase
  end

  // Output logic: the datapath mux is zero-cycle from the granted requester;
  // IDLE and FLUSH both hold the MAC in clear.
  always_comb begin
    gnt0_o       = 1'b0;
    gnt1_o       = 1'b0;
    rom_addr_o   = '0;
    rom_rd_en_o  = 1'b0;
    mac_active_o = 1'b0;
    mac_rst_n_o  = 1'b0;
    case (state_q)
      ST_GRANT0: begin
        gnt0_o       = 1'b1;
        mac_rst_n_o  = 1'b1;
        rom_addr_o   = addr0_i;
        rom_rd_en_o  = rd_en0_i;
        mac_active_o = acc0_i;
      end
      ST_GRANT1: begin
        gnt1_o       = 1'b1;
        mac_rst_n_o  = 1'b1;
        rom_addr_o   = addr1_i;
        rom_rd_en_o  = rd_en1_i;
        mac_active_o = acc1_i;
      end
      default: begin
      end
    endcase
  end

  // Pointer, op counter, result capture and sticky error
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q        <= 1'b0;
      ops_q        <= '0;
      res0_q       <= '0;
      res1_q       <= '0;
      res_valid0_q <= 1'b0;
      res_valid1_q <= 1'b0;
      wd_err_q     <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      ops_q        <= ops_d;
      res_valid0_q <= cap0;
      res_valid1_q <= cap1;
      if (cap0) res0_q <= mac_result_i;
      if (cap1) res1_q <= mac_result_i;
      if (wd_fire) wd_err_q <= 1'b1;
    end
  end

  assign res0_o       = res0_q;
  assign res1_o       = res1_q;
  assign res_valid0_o = res_valid0_q;
  assign res_valid1_o = res_valid1_q;
  assign wd_err_o     = wd_err_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// tb/tb_mac_arbiter.sv - self-checking bench for mac_arbiter
module tb_mac_arbiter;
  localparam int DW     = 16;
  localparam int AW     = 6;
  localparam int MAXOPS = 64;
`ifdef MAC_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req   [2];
  logic [AW-1:0] addr  [2];
  logic          rd_en [2];
  logic          acc   [2];
  logic          done  [2];
  logic [DW-1:0] mac_result;
  logic          gnt0_o, gnt1_o, rom_rd_en_o, mac_active_o, mac_rst_n_o;
  logic [AW-1:0] rom_addr_o;
  logic [DW-1:0] res0_o, res1_o;
  logic          res_valid0_o, res_valid1_o, wd_err_o;

  mac_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_OPS(MAXOPS)) dut (
    .clock        (clock),
    .reset        (reset),
    .req0_i       (req[0]),
    .req1_i       (req[1]),
    .addr0_i      (addr[0]),
    .addr1_i      (addr[1]),
    .rd_en0_i     (rd_en[0]),
    .rd_en1_i     (rd_en[1]),
    .acc0_i       (acc[0]),
    .acc1_i       (acc[1]),
    .done0_i      (done[0]),
    .done1_i      (done[1]),
    .mac_result_i (mac_result),
    .gnt0_o       (gnt0_o),
    .gnt1_o       (gnt1_o),
    .rom_addr_o   (rom_addr_o),
    .rom_rd_en_o  (rom_rd_en_o),
    .mac_active_o (mac_active_o),
    .mac_rst_n_o  (mac_rst_n_o),
    .res0_o       (res0_o),
    .res1_o       (res1_o),
    .res_valid0_o (res_valid0_o),
    .res_valid1_o (res_valid1_o),
    .wd_err_o     (wd_err_o)
  );

  always #5 clock = ~clock;

  // Model: who owns the datapath (-1 = nobody). A released grant always
  // leaves one cycle with no owner, and the no-owner cycle arbitrates.
  int            m_owner;
  bit            m_ptr;
  int            m_ops;
  logic [DW-1:0] m_res [2];
  bit            m_rv  [2];
  bit            m_wd;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 1'b0;
    m_ops   = 0;
    m_res[0] = '0;
    m_res[1] = '0;
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    m_wd    = 1'b0;
  endtask

  task automatic model_step();
    int k;
    bit rel;
    m_rv[0] = 1'b0;
    m_rv[1] = 1'b0;
    if (m_owner >= 0) begin
      k   = m_owner;
      rel = 1'b0;
      if (done[k]) begin
        m_res[k] = mac_result;
        m_rv[k]  = 1'b1;
        rel      = 1'b1;
      end else if (!req[k]) begin
        rel = 1'b1;
      end else if (WD && acc[k] && m_ops == MAXOPS) begin
        m_wd = 1'b1;
        rel  = 1'b1;
      end else if (acc[k]) begin
        m_ops++;
      end
      if (rel) begin
        m_owner = -1;
        m_ptr   = (k == 0);
        m_ops   = 0;
      end
    end else begin
      m_ops = 0;
      if (req[0] && req[1]) m_owner = m_ptr ? 1 : 0;
      else if (req[0])      m_owner = 0;
      else if (req[1])      m_owner = 1;
    end
  endtask

  task automatic compare();
    logic [AW-1:0] ea;
    ea = (m_owner >= 0) ? addr[m_owner] : '0;
    chk("gnt0",       gnt0_o,       m_owner == 0);
    chk("gnt1",       gnt1_o,       m_owner == 1);
    chk("rom_addr",   rom_addr_o,   ea);
    chk("rom_rd_en",  rom_rd_en_o,  (m_owner >= 0) ? rd_en[m_owner] : 1'b0);
    chk("mac_active", mac_active_o, (m_owner >= 0) ? acc[m_owner] : 1'b0);
    chk("mac_rst_n",  mac_rst_n_o,  m_owner >= 0);
    chk("res0",       res0_o,       m_res[0]);
    chk("res1",       res1_o,       m_res[1]);
    chk("res_valid0", res_valid0_o, m_rv[0]);
    chk("res_valid1", res_valid1_o, m_rv[1]);
    chk("wd_err",     wd_err_o,     m_wd);
  endtask

  always @(negedge clock) begin
    if (chk_en && reset) compare();
  end

  task automatic cycle();
    @(posedge clock);
    if (!reset) model_reset();
    else        model_step();
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; addr[k] = '0; rd_en[k] = 1'b0; acc[k] = 1'b0; done[k] = 1'b0;
    end
    mac_result = '0;
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    model_reset();
    repeat (2) cycle();
    reset = 1'b1;
  endtask

  initial begin
    int po;
    clear_inputs();
    model_reset();
    chk_en = 1'b1;
    repeat (3) cycle();
    reset = 1'b1;
    #1;
    chk("rst_gnt0", gnt0_o, 0);
    chk("rst_mac_rst_n", mac_rst_n_o, 0);
    chk("rst_res0", res0_o, 0);
    chk("rst_wd_err", wd_err_o, 0);

    // Single requester: grant latency, address stream, capture, back-to-back
    req[0] = 1'b1;
    cycle();
    #1 chk("t1_gnt0", gnt0_o, 1);
    for (int i = 0; i < 64; i++) begin
      addr[0] = AW'(i); acc[0] = 1'b1; rd_en[0] = 1'b1;
      addr[1] = AW'(63 - i); acc[1] = 1'b0; rd_en[1] = 1'b0;
      #1;
      chk("t1_rom_addr", rom_addr_o, i);
      chk("t1_mac_active", mac_active_o, 1);
      cycle();
    end
    acc[0] = 1'b0; rd_en[0] = 1'b0;
    done[0] = 1'b1; mac_result = 16'h1234;
    cycle();
    done[0] = 1'b0;
    #1;
    chk("t1_res0", res0_o, 16'h1234);
    chk("t1_res_valid0", res_valid0_o, 1);
    chk("t1_flush_rst_n", mac_rst_n_o, 0);
    chk("t1_flush_gnt0", gnt0_o, 0);
    cycle();
    #1;
    chk("t1_b2b_gnt0", gnt0_o, 1);
    chk("t1_rv0_once", res_valid0_o, 0);
    chk("t1_b2b_rst_n", mac_rst_n_o, 1);
    req[0] = 1'b0;
    repeat (2) cycle();

    // Both requesters together: alternation
    reset_pulse();
    req[0] = 1'b1; req[1] = 1'b1;
    cycle();
    #1 chk("t2_first_gnt0", gnt0_o, 1);
    chk("t2_first_gnt1", gnt1_o, 0);
    done[0] = 1'b1; mac_result = 16'h00A5;
    cycle();
    done[0] = 1'b0;
    #1 chk("t2_dead_gnt1", gnt1_o, 0);
    cycle();
    #1 chk("t2_gnt1", gnt1_o, 1);
    done[1] = 1'b1; mac_result = 16'h5A5A;
    cycle();
    done[1] = 1'b0;
    #1 chk("t2_res1", res1_o, 16'h5A5A);
    chk("t2_rv1", res_valid1_o, 1);
    cycle();
    #1 chk("t2_again_gnt0", gnt0_o, 1);

    // Requester 1 drops mid-grant without done
    done[0] = 1'b1; mac_result = 16'h0101;
    cycle();
    done[0] = 1'b0;
    cycle();
    #1 chk("t3_gnt1", gnt1_o, 1);
    req[1] = 1'b0; mac_result = 16'hFFFF;
    cycle();
    #1 chk("t3_no_rv1", res_valid1_o, 0);
    chk("t3_res1_kept", res1_o, 16'h5A5A);
    cycle();
    #1 chk("t3_next_gnt0", gnt0_o, 1);

    // done0 and req0 fall together
    done[0] = 1'b1; req[0] = 1'b0; mac_result = 16'hBEEF;
    cycle();
    done[0] = 1'b0;
    #1 chk("t4_rv0", res_valid0_o, 1);
    chk("t4_res0", res0_o, 16'hBEEF);
    cycle();
    #1 chk("t4_idle", gnt0_o | gnt1_o, 0);

    // Watchdog: 65 strobes without done
    req[0] = 1'b1;
    cycle();
    for (int i = 0; i < 65; i++) begin
      acc[0] = 1'b1;
      cycle();
    end
    acc[0] = 1'b0;
    #1 chk("t5_gnt0", gnt0_o, !WD);
    chk("t5_wd_err", wd_err_o, WD);
    chk("t5_no_rv0", res_valid0_o, 0);
    repeat (3) cycle();
    #1 chk("t5_wd_sticky", wd_err_o, WD);
    req[0] = 1'b0;
    repeat (2) cycle();

    // Reset during GRANT1
    req[1] = 1'b1;
    cycle();
    #1 chk("t6_gnt1", gnt1_o, 1);
    acc[1] = 1'b1;
    #1 chk("t6_mac_active", mac_active_o, 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_gnt1", gnt1_o, 0);
    chk("t6_rst_active", mac_active_o, 0);
    chk("t6_rst_rv1", res_valid1_o, 0);
    chk("t6_rst_wd", wd_err_o, 0);
    repeat (2) cycle();
    acc[1] = 1'b0;
    req[0] = 1'b1;
    reset = 1'b1;
    cycle();
    #1 chk("t6_ptr0_gnt0", gnt0_o, 1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      po = m_owner;
      cycle();
      for (int k = 0; k < 2; k++) begin
        if (m_owner == k) begin
          done[k] = ($urandom % 8 == 0);
          if ($urandom % 16 == 0) req[k] = 1'b0;
        end else begin
          done[k] = ($urandom % 32 == 0);
          if (po == k)      req[k] = 1'($urandom % 2);
          else if (!req[k]) req[k] = ($urandom % 3 == 0);
        end
        addr[k]  = AW'($urandom);
        rd_en[k] = 1'($urandom % 2);
        acc[k]   = 1'($urandom % 2);
      end
      mac_result = DW'($urandom);
    end
    cycle();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Round-robin arbiter sharing one coefficient ROM port and one MAC unit between two transform sequencers (requesters 0 and 1). The arbiter grants the shared datapath to one requester at a time and holds the grant for one complete coefficient computation. On hand-over it clears the MAC, and it captures each finished accumulation into a per-requester result register. It sits between the per-channel sequencers and the single ROM/MAC datapath.

## Interface
- DATA_W, 16, MAC result width
- ADDR_W, 6, ROM address width ({u,v})
- MAX_OPS, 64, accumulate strobes allowed per grant before the watchdog fires

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- req0 / req1  in  1  request for the datapath; held high until served
- addr0 / addr1  in  ADDR_W  requester ROM address
- rd_en0 / rd_en1  in  1  requester ROM read enable
- acc0 / acc1  in  1  requester accumulate strobe
- done0 / done1  in  1  single-cycle pulse: current coefficient complete
- mac_result  in  DATA_W  MAC accumulator output
- gnt0 / gnt1  out  1  registered grant, one-hot or zero
- rom_addr  out  ADDR_W  muxed ROM address
- rom_rd_en  out  1  muxed ROM read enable
- mac_active  out  1  muxed accumulate enable
- mac_rst_n  out  1  MAC clear, active-low
- res0 / res1  out  DATA_W  captured result per requester
- res_valid0 / res_valid1  out  1  one-cycle pulse when the matching res updates
- wd_err  out  1  sticky watchdog error

## Operation
- States: IDLE, GRANT0, GRANT1, FLUSH. Reset enters IDLE.
- Priority pointer `ptr`: 0 favours requester 0, 1 favours requester 1. Reset value is 0.
- IDLE:
  - Only one req high: go to GRANT of that requester.
  - Both req high: go to GRANT of the requester selected by `ptr`.
  - Neither high: stay in IDLE.
- GRANTk:
  - gntk=1. mac_rst_n=1.
  - rom_addr, rom_rd_en and mac_active are driven combinationally from requester k (zero-cycle mux).
  - Inputs from the non-granted requester are ignored.
- Exit from GRANTk:
  - donek=1: resk <= mac_result on that edge; res_validk=1 for the next cycle; `ptr` <= ~k; go to FLUSH.
  - reqk=0 with donek=0: go to FLUSH, no capture, `ptr` <= ~k.
  - donek=1 and reqk=0 in the same cycle: done wins, result is captured.
- FLUSH (exactly 1 cycle):
  - gnt0=gnt1=0. mac_rst_n=0. rom_addr=0, rom_rd_en=0, mac_active=0.
  - Next state is chosen by the same rule as IDLE, using the updated `ptr`.
- IDLE outputs: identical to FLUSH outputs, including mac_rst_n=0.
- Op counter: ADDR_W+1 bits. Increments on each cycle in GRANTk with acck=1. Cleared in FLUSH and IDLE.
- Reset values: all outputs 0, res0=res1=0, state IDLE, ptr=0. Reset asserted mid-grant aborts immediately: no capture, grant drops asynchronously.

## Timing
- Grant latency: req rises at edge n, gnt asserts after edge n+1. Requesters must not drive rd_en/acc before they see gnt.
- Hand-over: done at edge n, FLUSH during cycle n+1, next grant visible after edge n+2. This gives 1 dead cycle between grants.
- res_validk pulses during the FLUSH cycle, and resk is already stable in that cycle.
- Back-to-back requests from the same requester with no competitor: GRANTk, FLUSH, GRANTk. The MAC is cleared every time.

## Configuration
- MAC_ARB_WATCHDOG_EN defined:
  - If acck=1 while the op counter equals MAX_OPS, the arbiter forces FLUSH on that edge.
  - No capture occurs. `ptr` <= ~k.
  - wd_err sets and stays 1 until reset.
- MAC_ARB_WATCHDOG_EN undefined:
  - There is no forced release; a grant is held until done or req drop.
  - wd_err is tied to 0.

## Test plan
- Reset, then req0=1 alone: gnt0=1 after 1 cycle. 64 acc0 strobes with addr0 stepping 0..63 appear on rom_addr/mac_active in the same cycle. done0 with mac_result=16'h1234 gives res0=16'h1234, one res_valid0 pulse, and mac_rst_n=0 for 1 cycle.
- req0 and req1 both rise together after reset: requester 0 is granted first. After done0, FLUSH runs, then gnt1. After done1, with both still high, gnt0 again (alternation).
- req1 drops mid-grant without done1: FLUSH, no res_valid1, res1 unchanged, next grant goes to requester 0 if requesting.
- done0 and req0 fall in the same cycle: capture occurs and res_valid0 pulses.
- With MAC_ARB_WATCHDOG_EN and MAX_OPS=64: 65 acc0 strobes without done0 force FLUSH on the 65th, wd_err=1 and stays 1, no res_valid0. Without the macro: the grant is held and wd_err=0.
- Reset asserted during GRANT1: gnt1, mac_active and res_valid1 are 0 immediately; after release the arbiter is in IDLE with ptr=0.
